// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver. Display data is double-buffered
// and only swapped at frame boundaries, so a digit never changes mid-frame.
module seg7_scan_driver #(
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] ld_data,
  input  logic [7:0]  ld_dp,
  input  logic [7:0]  ld_blank,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic [7:0]  seg,
  output logic [7:0]  sel,
  output logic        frame_start
);

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
  } disp_t;

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);
  localparam logic [15:0] GUARD_W  = 16'(GUARD);
  localparam logic [7:0]  SEG_RST  = (GUARD > 0) ? 8'hFF : 8'h03;

  function automatic logic [7:0] hex_code(input logic [3:0] n);
    case (n)
      4'h0: hex_code = 8'hFC;
      4'h1: hex_code = 8'h60;
      4'h2: hex_code = 8'hDA;
      4'h3: hex_code = 8'hF2;
      4'h4: hex_code = 8'h66;
      4'h5: hex_code = 8'hB6;
      4'h6: hex_code = 8'hBE;
      4'h7: hex_code = 8'hE0;
      4'h8: hex_code = 8'hFE;
      4'h9: hex_code = 8'hF6;
      4'hA: hex_code = 8'hEE;
      4'hB: hex_code = 8'h3E;
      4'hC: hex_code = 8'h9C;
      4'hD: hex_code = 8'h7A;
      4'hE: hex_code = 8'h9E;
      default: hex_code = 8'h8E;
    endcase
  endfunction

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  disp_t       pend_q, pend_d;
  disp_t       act_q, act_d;
  logic        ready_q, ready_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  sel_q, sel_d;
  logic        fs_q, fs_d;
  logic        tick, wrap, accept, in_guard;
  logic [3:0]  nib;
  logic [7:0]  code;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d = idx_q + {2'b00, tick};
    wrap  = tick && (idx_q == 3'd7);
  end

  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt_d < GUARD_W);
    end
  endgenerate

  // Outputs are computed from next-state values so they line up with cnt/idx.
  always_comb begin
    accept  = ld_valid && ready_q;
    pend_d  = pend_q;
    act_d   = act_q;
    ready_d = ready_q;
    if (accept) begin
      pend_d  = {ld_data, ld_dp, ld_blank};
      ready_d = 1'b0;
    end else if (wrap && !ready_q) begin
      act_d   = pend_q;
      ready_d = 1'b1;
    end
    nib  = act_d.data[{idx_d, 2'b00} +: 4];
    code = hex_code(nib);
    if (in_guard || act_d.blank[idx_d]) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = ~{code[7:1], act_d.dp[idx_d]};
    end
    sel_d = 8'b0000_0001 << idx_d;
    fs_d  = wrap;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      pend_q  <= '0;
      act_q   <= '0;
      ready_q <= 1'b1;
      seg_q   <= SEG_RST;
      sel_q   <= 8'h01;
      fs_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      ready_q <= ready_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      fs_q    <= fs_d;
    end
  end

  assign ld_ready    = ready_q;
  assign seg         = seg_q;
  assign sel         = sel_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random loads,
// compared every cycle against a time-based model of the scan.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int GUARD = 1;
  localparam int FRAME = DIV * 8;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic [31:0] ld_data = '0;
  logic [7:0]  ld_dp = '0;
  logic [7:0]  ld_blank = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  seg;
  logic [7:0]  sel;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  logic [7:0] code_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Model: cycles since reset release, plus the two display buffers.
  int          m_t;
  logic        m_ready;
  logic [31:0] m_pend_data, m_act_data;
  logic [7:0]  m_pend_dp, m_act_dp, m_pend_blank, m_act_blank;

  seg7_scan_driver #(.DIV(DIV), .GUARD(GUARD)) dut (
    .CLK(CLK), .CLR(CLR), .ld_data(ld_data), .ld_dp(ld_dp), .ld_blank(ld_blank),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .seg(seg), .sel(sel),
    .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0d: got %0h expected %0h", tag, m_t, got, exp);
    end
  endtask

  task automatic modelReset();
    m_t = 0;
    m_ready = 1'b1;
    m_pend_data = '0; m_pend_dp = '0; m_pend_blank = '0;
    m_act_data  = '0; m_act_dp  = '0; m_act_blank  = '0;
  endtask

  task automatic compareAll();
    int          cnt, idx;
    logic [3:0]  n;
    logic [7:0]  c, exp_seg;
    cnt = m_t % DIV;
    idx = (m_t / DIV) % 8;
    n = 4'((m_act_data >> (4 * idx)) & 32'hF);
    c = code_tab[n];
    if (cnt < GUARD || m_act_blank[idx]) exp_seg = 8'hFF;
    else exp_seg = ~{c[7:1], m_act_dp[idx]};
    checkOutput("seg", {24'd0, seg}, {24'd0, exp_seg});
    checkOutput("sel", {24'd0, sel}, 32'd1 << idx);
    checkOutput("ld_ready", {31'd0, ld_ready}, {31'd0, m_ready});
    checkOutput("frame_start", {31'd0, frame_start},
                {31'd0, (m_t > 0) && (m_t % FRAME == 0)});
  endtask

  // Called at a negedge: check, drive one cycle of inputs, advance model, return at next negedge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [7:0] dp,
                               input logic [7:0] bl);
    compareAll();
    ld_valid = v; ld_data = d; ld_dp = dp; ld_blank = bl;
    @(posedge CLK);
    if (v && m_ready) begin
      m_pend_data = d; m_pend_dp = dp; m_pend_blank = bl;
      m_ready = 1'b0;
    end else if (((m_t + 1) % FRAME == 0) && !m_ready) begin
      m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
      m_ready = 1'b1;
    end
    m_t++;
    @(negedge CLK);
    ld_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 8'h0, 8'h0);
  endtask

  task automatic doReset();
    #2 CLR = 1'b0;
    #1;
    checkOutput("rst_sel", {24'd0, sel}, 32'h01);
    checkOutput("rst_seg", {24'd0, seg}, 32'hFF);
    checkOutput("rst_ready", {31'd0, ld_ready}, 32'd1);
    checkOutput("rst_fs", {31'd0, frame_start}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_hold_sel", {24'd0, sel}, 32'h01);
    CLR = 1'b1;
    modelReset();
  endtask

  initial begin
    modelReset();
    @(negedge CLK);
    doReset();

    // Idle scan over a frame boundary.
    idle(FRAME + 8);

    // Load at cycle 10, ignored second request, two frames displayed.
    @(negedge CLK);
    doReset();
    idle(10);
    applyStimulus(1'b1, 32'h76543210, 8'h00, 8'h00);
    idle(4);
    applyStimulus(1'b1, 32'hFFFFFFFF, 8'hFF, 8'h00);
    idle(2 * FRAME);

    // Blank digit 7, decimal point on digit 0.
    applyStimulus(1'b1, 32'h0, 8'h01, 8'h80);
    idle(2 * FRAME);

    // Load accepted on the wrap-tick cycle itself.
    while ((m_t % FRAME) != FRAME - 1 || !m_ready) idle(1);
    applyStimulus(1'b1, 32'hFEDCBA98, 8'hA5, 8'h00);
    idle(2 * FRAME + 4);

    // Reset with a pending load while digit 5 is shown.
    applyStimulus(1'b1, 32'h13579BDF, 8'h0F, 8'h00);
    while ((m_t % FRAME) / DIV != 5) idle(1);
    doReset();
    idle(FRAME + 4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0), $urandom, 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
      if (i == 1500) doReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIV, default 50000: clock cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have parameter GUARD, default 2: blanked cycles at the start of each digit slot; legal range 0..DIV-1.
REQ-003 SHALL have port CLK, input, 1: single clock; all state rises on posedge CLK.
REQ-004 SHALL have port CLR, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ld_data, input, 32: eight hex nibbles; digit i = ld_data[4i+3:4i].
REQ-006 SHALL have port ld_dp, input, 8: decimal point per digit; bit i lights dp of digit i when 1.
REQ-007 SHALL have port ld_blank, input, 8: bit i = 1 blanks digit i entirely.
REQ-008 SHALL have port ld_valid, input, 1: load request.
REQ-009 SHALL have port ld_ready, output, 1: load can be accepted.
REQ-010 SHALL have port seg, output, 8: segments, active-low, bit7..bit0 = a,b,c,d,e,f,g,dp.
REQ-011 SHALL have port sel, output, 8: digit select, one-hot, active-high; bit i = digit i.
REQ-012 SHALL have port frame_start, output, 1: one-cycle pulse at the start of each scan frame.

Function
REQ-013 SHALL keep prescaler cnt counting 0..DIV-1; tick = (cnt == DIV-1); cnt returns to 0 on tick.
REQ-014 SHALL keep 3-bit digit index idx, incremented on tick, wrapping 7->0.
REQ-015 SHALL hold two 48-bit buffers {data, dp, blank}: pending and active.
REQ-016 SHALL accept a load on a cycle with ld_valid=1 and ld_ready=1, capturing ld_data/ld_dp/ld_blank into pending and driving ld_ready to 0 from the next cycle.
REQ-017 SHALL ignore ld_valid while ld_ready=0; the pending buffer is unchanged.
REQ-018 SHALL copy pending to active at the wrap edge (tick with idx=7) while ld_ready=0, and drive ld_ready to 1 from that same edge; active is never changed mid-frame.
REQ-019 SHALL, for a load accepted on the wrap-tick cycle itself, transfer it at the following wrap, not the current one.
REQ-020 SHALL register seg and sel from next-state values, so that sel = onehot(idx) and seg reflects the current cnt/idx/active buffer in the same cycle (no extra lag).
REQ-021 SHALL drive seg = 8'hFF when cnt < GUARD or active.blank[idx]=1; otherwise seg = ~{code(nibble[idx])[7:1], active.dp[idx]}.
REQ-022 SHALL use code (hex, a..g in bits 7..1): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 A=EE b=3E C=9C d=7A E=9E F=8E.
REQ-023 SHALL drive frame_start = 1 for exactly the one cycle in which idx=0 and cnt=0 following a wrap edge, and 0 otherwise.

Reset
REQ-024 SHALL, with CLR=0, force immediately: cnt=0, idx=0, pending and active = all zero, ld_ready=1, sel=8'h01, seg=8'hFF if GUARD>0 else 8'h03, frame_start=0.
REQ-025 SHALL, when CLR is asserted mid-frame or with a pending load, discard the pending load and restart the scan from digit 0 on release.
REQ-026 SHALL advance cnt on the first posedge CLK after CLR deasserts; no frame_start pulse is issued for the post-reset frame.

Verification (DIV=4, GUARD=1)
REQ-027 SHALL cover: reset release -> sel=01 for 4 cycles with seg FF,03,03,03, then sel=02; full frame = 32 cycles; sel returns to 01 at cycle 32 with frame_start=1.
REQ-028 SHALL cover: ld_data=32'h76543210, dp=0, blank=0 loaded at cycle 10 -> ld_ready=0 from cycle 11 to the wrap; next frame shows digit0 seg=03, digit1 9F, digit2 25, digit3 0D; ld_ready=1 at that frame start.
REQ-029 SHALL cover: second ld_valid while ld_ready=0 -> ignored; displayed data matches the first load.
REQ-030 SHALL cover: load with ld_blank=8'h80 and ld_dp=8'h01, data=0 -> digit7 seg=FF in every cycle; digit0 non-guard seg=02.
REQ-031 SHALL cover: load accepted exactly on the wrap-tick cycle -> old data shown for one more full frame; new data appears at the next wrap.
REQ-032 SHALL cover: CLR pulsed low with a load pending at idx=5 -> immediate sel=01, seg=FF, ld_ready=1; the display shows zeros after release.
